// File: rtl/alu_rs_gen2.sv
// ALU reservation station: tag-based operand wakeup over the CDB,
// oldest-first selection via an age matrix, registered dispatch port.
module alu_rs_gen2 #(
    parameter int DEPTH     = 16,
    parameter int CDB_PORTS = 2,
    parameter int TAG_W     = 4,
    parameter int XLEN      = 32,
    parameter int OP_W      = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OP_W-1:0]               in_op,
    input  logic [XLEN-1:0]               in_imm,
    input  logic [XLEN-1:0]               in_pc,
    input  logic [5:0]                    in_shamt,
    input  logic [TAG_W-1:0]              in_dest,
    input  logic [XLEN-1:0]               in_src1_val,
    input  logic [XLEN-1:0]               in_src2_val,
    input  logic [TAG_W-1:0]              in_src1_tag,
    input  logic [TAG_W-1:0]              in_src2_tag,
    input  logic                          in_src1_rdy,
    input  logic                          in_src2_rdy,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]     cdb_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OP_W-1:0]               out_op,
    output logic [XLEN-1:0]               out_imm,
    output logic [XLEN-1:0]               out_pc,
    output logic [5:0]                    out_shamt,
    output logic [TAG_W-1:0]              out_dest,
    output logic [XLEN-1:0]               out_src1,
    output logic [XLEN-1:0]               out_src2,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] busy, r1, r2;
    logic [OP_W-1:0]  e_op    [DEPTH];
    logic [XLEN-1:0]  e_imm   [DEPTH];
    logic [XLEN-1:0]  e_pc    [DEPTH];
    logic [5:0]       e_shamt [DEPTH];
    logic [TAG_W-1:0] e_dest  [DEPTH];
    logic [XLEN-1:0]  e_v1    [DEPTH];
    logic [XLEN-1:0]  e_v2    [DEPTH];
    logic [TAG_W-1:0] e_t1    [DEPTH];
    logic [TAG_W-1:0] e_t2    [DEPTH];
    // age[i][j] set means entry i was issued before entry j
    logic [DEPTH-1:0] age     [DEPTH];

    logic [DEPTH-1:0] w1_hit, w2_hit, elig;
    logic [XLEN-1:0]  w1_data [DEPTH];
    logic [XLEN-1:0]  w2_data [DEPTH];
    logic             b1_hit, b2_hit;
    logic [XLEN-1:0]  b1_data, b2_data;
    logic [IW-1:0]    sel_idx, free_idx;
    logic             any_elig, issue, load, disp;

    // lowest-numbered matching port wins
    function automatic logic [XLEN:0] cdb_look(
        input logic [TAG_W-1:0]           t,
        input logic [CDB_PORTS-1:0]       v,
        input logic [CDB_PORTS*TAG_W-1:0] tg,
        input logic [CDB_PORTS*XLEN-1:0]  d
    );
        logic [XLEN:0] r;
        r = '0;
        for (int p = CDB_PORTS-1; p >= 0; p--) begin
            if (v[p] && tg[p*TAG_W +: TAG_W] == t)
                r = {1'b1, d[p*XLEN +: XLEN]};
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {w1_hit[i], w1_data[i]} = cdb_look(e_t1[i], cdb_valid, cdb_tag, cdb_data);
            {w2_hit[i], w2_data[i]} = cdb_look(e_t2[i], cdb_valid, cdb_tag, cdb_data);
        end
        {b1_hit, b1_data} = cdb_look(in_src1_tag, cdb_valid, cdb_tag, cdb_data);
        {b2_hit, b2_data} = cdb_look(in_src2_tag, cdb_valid, cdb_tag, cdb_data);
    end

    always_comb begin
        logic [DEPTH-1:0] older;
        older    = '0;
        sel_idx  = '0;
        elig     = busy & r1 & r2;
        any_elig = |elig;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++)
                older[j] = age[j][i];
            if (elig[i] && !(|(older & elig)))
                sel_idx = IW'(i);
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!busy[i])
                free_idx = IW'(i);
        end
    end

    assign in_ready = (occupancy != CW'(DEPTH));
    assign issue    = in_valid && in_ready && rdy && !flush;
    assign load     = rdy && (!out_valid || out_ready);
    assign disp     = load && any_elig;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            r1        <= '0;
            r2        <= '0;
            for (int i = 0; i < DEPTH; i++)
                age[i] <= '0;
            out_valid <= 1'b0;
            occupancy <= '0;
            out_op    <= '0;
            out_imm   <= '0;
            out_pc    <= '0;
            out_shamt <= '0;
            out_dest  <= '0;
            out_src1  <= '0;
            out_src2  <= '0;
        end else if (flush) begin
            busy      <= '0;
            for (int i = 0; i < DEPTH; i++)
                age[i] <= '0;
            out_valid <= 1'b0;
            occupancy <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && !r1[i] && w1_hit[i]) begin
                    r1[i]   <= 1'b1;
                    e_v1[i] <= w1_data[i];
                end
                if (busy[i] && !r2[i] && w2_hit[i]) begin
                    r2[i]   <= 1'b1;
                    e_v2[i] <= w2_data[i];
                end
            end
            if (disp)
                busy[sel_idx] <= 1'b0;
            if (issue) begin
                busy[free_idx]    <= 1'b1;
                e_op[free_idx]    <= in_op;
                e_imm[free_idx]   <= in_imm;
                e_pc[free_idx]    <= in_pc;
                e_shamt[free_idx] <= in_shamt;
                e_dest[free_idx]  <= in_dest;
                e_t1[free_idx]    <= in_src1_tag;
                e_t2[free_idx]    <= in_src2_tag;
                r1[free_idx]      <= in_src1_rdy || b1_hit;
                r2[free_idx]      <= in_src2_rdy || b2_hit;
                e_v1[free_idx]    <= in_src1_rdy ? in_src1_val : b1_data;
                e_v2[free_idx]    <= in_src2_rdy ? in_src2_val : b2_data;
                // new entry is younger than everything already present
                for (int i = 0; i < DEPTH; i++)
                    age[i][free_idx] <= (IW'(i) != free_idx);
                age[free_idx] <= '0;
            end
            if (load) begin
                out_valid <= any_elig;
                if (any_elig) begin
                    out_op    <= e_op[sel_idx];
                    out_imm   <= e_imm[sel_idx];
                    out_pc    <= e_pc[sel_idx];
                    out_shamt <= e_shamt[sel_idx];
                    out_dest  <= e_dest[sel_idx];
                    out_src1  <= e_v1[sel_idx];
                    out_src2  <= e_v2[sel_idx];
                end
            end
            occupancy <= occupancy + CW'(issue) - CW'(disp);
        end
    end

endmodule

// File: tb/tb_alu_rs_gen2.sv
// Bench for alu_rs_gen2: directed scenarios plus random traffic
// checked against a sequence-numbered behavioural model.
module tb_alu_rs_gen2;

    localparam int D  = 16;
    localparam int P  = 2;
    localparam int TW = 4;
    localparam int XL = 32;
    localparam int OW = 6;

    logic            clk;
    logic            rst, rdy, flush, in_valid, in_ready;
    logic [OW-1:0]   in_op;
    logic [XL-1:0]   in_imm, in_pc;
    logic [5:0]      in_shamt;
    logic [TW-1:0]   in_dest;
    logic [XL-1:0]   in_src1_val, in_src2_val;
    logic [TW-1:0]   in_src1_tag, in_src2_tag;
    logic            in_src1_rdy, in_src2_rdy;
    logic [P-1:0]    cdb_valid;
    logic [P*TW-1:0] cdb_tag;
    logic [P*XL-1:0] cdb_data;
    logic            out_valid, out_ready;
    logic [OW-1:0]   out_op;
    logic [XL-1:0]   out_imm, out_pc;
    logic [5:0]      out_shamt;
    logic [TW-1:0]   out_dest;
    logic [XL-1:0]   out_src1, out_src2;
    logic [4:0]      occupancy;

    alu_rs_gen2 #(
        .DEPTH(D), .CDB_PORTS(P), .TAG_W(TW), .XLEN(XL), .OP_W(OW)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_imm(in_imm), .in_pc(in_pc),
        .in_shamt(in_shamt), .in_dest(in_dest),
        .in_src1_val(in_src1_val), .in_src2_val(in_src2_val),
        .in_src1_tag(in_src1_tag), .in_src2_tag(in_src2_tag),
        .in_src1_rdy(in_src1_rdy), .in_src2_rdy(in_src2_rdy),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_imm(out_imm), .out_pc(out_pc),
        .out_shamt(out_shamt), .out_dest(out_dest),
        .out_src1(out_src1), .out_src2(out_src2),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic          busy;
        logic [31:0]   seq;
        logic [OW-1:0] op;
        logic [XL-1:0] imm;
        logic [XL-1:0] pc;
        logic [5:0]    shamt;
        logic [TW-1:0] dest;
        logic          r1;
        logic [XL-1:0] v1;
        logic [TW-1:0] t1;
        logic          r2;
        logic [XL-1:0] v2;
        logic [TW-1:0] t2;
    } ment_t;

    ment_t       m [D];
    ment_t       mo;
    bit          mov;
    int unsigned mseq;

    function automatic bit cdb_find(input logic [TW-1:0] t, output logic [XL-1:0] d);
        d = '0;
        for (int p = 0; p < P; p++) begin
            if (cdb_valid[p] && cdb_tag[p*TW +: TW] == t) begin
                d = cdb_data[p*XL +: XL];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < D; i++)
            if (m[i].busy) c++;
        return c;
    endfunction

    // advance the model with the current inputs, then clock the DUT
    task automatic step();
        ment_t nm [D];
        ment_t no;
        bit nov;
        int sel, fr, cnt;
        logic [XL-1:0] d;
        nm = m; no = mo; nov = mov;
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                nm[i].busy = 1'b0; nm[i].r1 = 1'b0; nm[i].r2 = 1'b0;
            end
            nov = 1'b0;
            no  = '0;
        end else if (flush) begin
            for (int i = 0; i < D; i++) nm[i].busy = 1'b0;
            nov = 1'b0;
        end else if (rdy) begin
            cnt = m_count();
            sel = -1;
            fr  = -1;
            for (int i = 0; i < D; i++) begin
                if (m[i].busy && m[i].r1 && m[i].r2 &&
                    (sel < 0 || m[i].seq < m[sel].seq))
                    sel = i;
                if (!m[i].busy && fr < 0) fr = i;
            end
            for (int i = 0; i < D; i++) begin
                if (m[i].busy && !m[i].r1 && cdb_find(m[i].t1, d)) begin
                    nm[i].r1 = 1'b1; nm[i].v1 = d;
                end
                if (m[i].busy && !m[i].r2 && cdb_find(m[i].t2, d)) begin
                    nm[i].r2 = 1'b1; nm[i].v2 = d;
                end
            end
            if (!mov || out_ready) begin
                if (sel >= 0) begin
                    nov = 1'b1;
                    no  = m[sel];
                    nm[sel].busy = 1'b0;
                end else begin
                    nov = 1'b0;
                end
            end
            if (in_valid && cnt < D) begin
                nm[fr].busy  = 1'b1;
                nm[fr].seq   = mseq;
                mseq++;
                nm[fr].op    = in_op;
                nm[fr].imm   = in_imm;
                nm[fr].pc    = in_pc;
                nm[fr].shamt = in_shamt;
                nm[fr].dest  = in_dest;
                nm[fr].t1    = in_src1_tag;
                nm[fr].t2    = in_src2_tag;
                nm[fr].r1    = 1'b1;
                nm[fr].r2    = 1'b1;
                nm[fr].v1    = in_src1_val;
                nm[fr].v2    = in_src2_val;
                if (!in_src1_rdy) begin
                    nm[fr].r1 = cdb_find(in_src1_tag, d);
                    nm[fr].v1 = d;
                end
                if (!in_src2_rdy) begin
                    nm[fr].r2 = cdb_find(in_src2_tag, d);
                    nm[fr].v2 = d;
                end
            end
        end
        @(posedge clk);
        #1;
        m = nm; mo = no; mov = nov;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; rdy = 1'b1; in_valid = 1'b0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic set_issue(input int op, input int v1, input int t1, input int r1,
                             input int v2, input int t2, input int r2, input int dest);
        in_valid    = 1'b1;
        in_op       = OW'(op);
        in_imm      = $urandom;
        in_pc       = $urandom;
        in_shamt    = 6'($urandom_range(0, 63));
        in_dest     = TW'(dest);
        in_src1_val = XL'(v1);
        in_src1_tag = TW'(t1);
        in_src1_rdy = r1[0];
        in_src2_val = XL'(v2);
        in_src2_tag = TW'(t2);
        in_src2_rdy = r2[0];
    endtask

    task automatic set_cdb(input int port, input int tag, input int data);
        cdb_valid[port]          = 1'b1;
        cdb_tag[port*TW +: TW]   = TW'(tag);
        cdb_data[port*XL +: XL]  = XL'(data);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        out_ready = 1'b1;
        set_issue(9, 1, 0, 1, 2, 0, 1, 3);
        step();
        step();
        idle();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready);
        end
        total++;
        if (occupancy !== 5'd0) begin
            bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy);
        end
        total++;
        if ({out_op, out_imm, out_pc, out_shamt, out_dest, out_src1, out_src2} !== '0) begin
            bad++; $display("FAIL reset_payload got op=%h src1=%h src2=%h dest=%h want all 0",
                            out_op, out_src1, out_src2, out_dest);
        end
    endtask

    task automatic test_basic();
        idle();
        out_ready = 1'b1;
        set_issue(3, 5, 0, 1, 7, 0, 1, 2);
        step();
        idle();
        total++;
        if (out_valid !== 1'b0 || occupancy !== 5'd1) begin
            bad++; $display("FAIL basic_issue_cycle got valid=%0b occ=%0d want valid=0 occ=1",
                            out_valid, occupancy);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_src1 !== 32'd5 || out_src2 !== 32'd7 ||
            out_dest !== 4'd2 || out_op !== 6'd3) begin
            bad++; $display("FAIL basic_dispatch got v=%0b s1=%0d s2=%0d d=%0d op=%0d want 1/5/7/2/3",
                            out_valid, out_src1, out_src2, out_dest, out_op);
        end
        total++;
        if (out_imm !== mo.imm || out_pc !== mo.pc || out_shamt !== mo.shamt) begin
            bad++; $display("FAIL basic_fields got imm=%h pc=%h sh=%0d want imm=%h pc=%h sh=%0d",
                            out_imm, out_pc, out_shamt, mo.imm, mo.pc, mo.shamt);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || occupancy !== 5'd0) begin
            bad++; $display("FAIL basic_drain got valid=%0b occ=%0d want 0/0", out_valid, occupancy);
        end
    endtask

    task automatic test_wakeup();
        idle();
        out_ready = 1'b1;
        set_issue(1, 0, 9, 0, 2, 0, 1, 10);
        step();
        set_issue(2, 3, 0, 1, 4, 0, 1, 11);
        step();
        idle();
        set_cdb(1, 9, 'h55);
        step();
        idle();
        total++;
        if (out_valid !== 1'b1 || out_dest !== 4'd11) begin
            bad++; $display("FAIL wakeup_first got v=%0b dest=%0d want 1/11", out_valid, out_dest);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_dest !== 4'd10 || out_src1 !== 32'h55 || out_src2 !== 32'd2) begin
            bad++; $display("FAIL wakeup_second got v=%0b dest=%0d s1=%h s2=%h want 1/10/55/2",
                            out_valid, out_dest, out_src1, out_src2);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || occupancy !== 5'd0) begin
            bad++; $display("FAIL wakeup_drain got v=%0b occ=%0d want 0/0", out_valid, occupancy);
        end
    endtask

    task automatic test_bypass();
        idle();
        out_ready = 1'b1;
        set_issue(4, 1, 0, 1, 0, 4, 0, 6);
        set_cdb(0, 4, 'hAB);
        set_cdb(1, 4, 'hCD);
        step();
        idle();
        total++;
        if (out_valid !== 1'b0 || occupancy !== 5'd1) begin
            bad++; $display("FAIL bypass_issue got v=%0b occ=%0d want 0/1", out_valid, occupancy);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_src2 !== 32'hAB || out_dest !== 4'd6) begin
            bad++; $display("FAIL bypass_dispatch got v=%0b s2=%h dest=%0d want 1/ab/6",
                            out_valid, out_src2, out_dest);
        end
        step();
    endtask

    task automatic test_full();
        idle();
        out_ready = 1'b0;
        for (int k = 0; k < D; k++) begin
            set_issue(k, k, 15, 0, k + 100, 0, 1, k);
            step();
        end
        idle();
        total++;
        if (in_ready !== 1'b0 || occupancy !== 5'd16) begin
            bad++; $display("FAIL full_state got rdy=%0b occ=%0d want 0/16", in_ready, occupancy);
        end
        set_issue(33, 1, 0, 1, 1, 0, 1, 7);
        step();
        idle();
        total++;
        if (occupancy !== 5'd16 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL full_ignore got occ=%0d rdy=%0b v=%0b want 16/0/0",
                            occupancy, in_ready, out_valid);
        end
        set_cdb(0, 15, 'h77);
        step();
        idle();
        step();
        total++;
        if (out_valid !== 1'b1 || out_dest !== 4'd0 || out_src1 !== 32'h77 ||
            occupancy !== 5'd15 || in_ready !== 1'b1) begin
            bad++; $display("FAIL full_first got v=%0b d=%0d s1=%h occ=%0d rdy=%0b want 1/0/77/15/1",
                            out_valid, out_dest, out_src1, occupancy, in_ready);
        end
    endtask

    task automatic test_stall_flush();
        idle();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_dest !== 4'd0 || out_src1 !== 32'h77 ||
                out_src2 !== 32'd100 || out_op !== 6'd0 || occupancy !== 5'd15) begin
                bad++; $display("FAIL stall_stable cyc=%0d got v=%0b d=%0d s1=%h s2=%0d occ=%0d",
                                k, out_valid, out_dest, out_src1, out_src2, occupancy);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_dest !== 4'd1 || occupancy !== 5'd14) begin
            bad++; $display("FAIL stall_pulse got v=%0b d=%0d occ=%0d want 1/1/14",
                            out_valid, out_dest, occupancy);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if (out_valid !== 1'b0 || occupancy !== 5'd0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_state got v=%0b occ=%0d rdy=%0b want 0/0/1",
                            out_valid, occupancy, in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL flush_no_dispatch cyc=%0d got v=%0b want 0", k, out_valid);
            end
        end
    endtask

    task automatic test_age();
        idle();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_issue(k, 0, k + 1, 0, 9, 0, 1, k);
            step();
        end
        idle();
        set_cdb(0, 4, 'h44);
        step();
        idle();
        step();
        total++;
        if (out_valid !== 1'b1 || out_dest !== 4'd3) begin
            bad++; $display("FAIL age_free3 got v=%0b d=%0d want 1/3", out_valid, out_dest);
        end
        set_issue(20, 0, 10, 0, 1, 0, 1, 12);
        step();
        idle();
        set_cdb(1, 2, 'h22);
        step();
        idle();
        step();
        total++;
        if (out_valid !== 1'b1 || out_dest !== 4'd1 || occupancy !== 5'd4) begin
            bad++; $display("FAIL age_free1 got v=%0b d=%0d occ=%0d want 1/1/4",
                            out_valid, out_dest, occupancy);
        end
        set_issue(21, 0, 10, 0, 1, 0, 1, 13);
        step();
        idle();
        set_cdb(0, 10, 'hA0);
        step();
        idle();
        step();
        total++;
        if (out_valid !== 1'b1 || out_dest !== 4'd12 || out_src1 !== 32'hA0) begin
            bad++; $display("FAIL age_oldest got v=%0b d=%0d s1=%h want 1/12/a0",
                            out_valid, out_dest, out_src1);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_dest !== 4'd13) begin
            bad++; $display("FAIL age_younger got v=%0b d=%0d want 1/13", out_valid, out_dest);
        end
        flush = 1'b1;
        step();
        idle();
    endtask

    task automatic test_random();
        int exp_occ;
        for (int c = 0; c < 800; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 59) == 0);
            rdy       = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 1) == 1)
                set_issue($urandom_range(0, 63), $urandom, $urandom_range(0, 15),
                          $urandom_range(0, 1), $urandom, $urandom_range(0, 15),
                          $urandom_range(0, 1), $urandom_range(0, 15));
            else
                in_valid = 1'b0;
            cdb_valid = P'($urandom_range(0, 3));
            cdb_tag   = P*TW'($urandom);
            cdb_data  = {$urandom, $urandom};
            step();
            exp_occ = m_count();
            total++;
            if (out_valid !== mov) begin
                bad++; $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", c, out_valid, mov);
            end
            total++;
            if (occupancy !== 5'(exp_occ)) begin
                bad++; $display("FAIL rand_occ cyc=%0d got=%0d want=%0d", c, occupancy, exp_occ);
            end
            total++;
            if (in_ready !== (exp_occ != D)) begin
                bad++; $display("FAIL rand_in_ready cyc=%0d got=%0b want=%0b", c, in_ready, exp_occ != D);
            end
            if (mov) begin
                total++;
                if ({out_op, out_imm, out_pc, out_shamt, out_dest, out_src1, out_src2} !==
                    {mo.op, mo.imm, mo.pc, mo.shamt, mo.dest, mo.v1, mo.v2}) begin
                    bad++; $display("FAIL rand_payload cyc=%0d got op=%h d=%h s1=%h s2=%h want op=%h d=%h s1=%h s2=%h",
                                    c, out_op, out_dest, out_src1, out_src2, mo.op, mo.dest, mo.v1, mo.v2);
                end
            end
        end
        idle();
    endtask

    initial begin
        mseq = 0;
        mov  = 1'b0;
        mo   = '0;
        for (int i = 0; i < D; i++) m[i] = '0;
        idle();
        out_ready = 1'b1;
        set_issue(0, 0, 0, 1, 0, 0, 1, 0);
        in_valid = 1'b0;
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full();
        test_stall_flush();
        test_age();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
